// File: rtl/regfile_dump.sv
// Streams register-file contents as (index, data) beats: reads a pair per FETCH, then emits even then odd.
// First beat 2 cycles after start, 3 cycles per pair; a beat holds until out_ready, abort cancels at any time.
module regfile_dump #(
  parameter int NUM_REGS = 32
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, DONE} state_t;

  localparam logic [4:0] LAST_PTR = 5'(NUM_REGS - 2);

  state_t      state;
  logic [4:0]  ptr;
  logic [31:0] buf0;
  logic [31:0] buf1;

  // ptr is always even, so the odd partner is ptr with bit 0 set
  assign ReadRegister1 = ptr;
  assign ReadRegister2 = ptr | 5'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      ptr       <= 5'd0;
      buf0      <= 32'd0;
      buf1      <= 32'd0;
      out_valid <= 1'b0;
      out_index <= 5'd0;
      out_data  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        ptr       <= 5'd0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state <= FETCH;
              ptr   <= 5'd0;
              busy  <= 1'b1;
            end
          end
          FETCH: begin
            buf0      <= ReadData1;
            buf1      <= ReadData2;
            out_valid <= 1'b1;
            out_index <= ptr;
            out_data  <= ReadData1;
            state     <= SEND0;
          end
          SEND0: begin
            if (out_ready) begin
              out_index <= ptr | 5'd1;
              out_data  <= buf1;
              state     <= SEND1;
            end
          end
          SEND1: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (ptr == LAST_PTR) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                ptr   <= ptr + 5'd2;
                state <= FETCH;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            ptr   <= 5'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
